control_seq: RTL

CONTROL_SEQ -- requirements
Module: control_seq

---
 rtl/control_seq.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/control_seq.sv
// Multi-cycle control sequencer: fetches an opcode, decodes it into a class and walks
// FETCH/DECODE/EXEC[/MEM][/WB], driving datapath strobes as Moore outputs of the state.
module control_seq #(
    parameter int OPW      = 3,
    parameter int MCW      = 4,
    parameter int MEM_WAIT = 2
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           Start,
    input  logic [MCW-1:0] Instr,
    output logic           UncdJmp,
    output logic           RdMem,
    output logic           WrMem,
    output logic           JType,
    output logic           IType,
    output logic           RegWrite,
    output logic           Movf,
    output logic [OPW-1:0] ALUOp,
    output logic           IRLoad,
    output logic           PCEn,
    output logic           Busy,
    output logic           Halted
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [3:0] CNT_LOAD = 4'(MEM_WAIT);

    logic [2:0]     state_reg, state_next;
    logic [MCW-1:0] opcode_reg, opcode_next;
    logic [3:0]     cnt_reg, cnt_next;

    logic [3:0]     op4;
    logic           hi_zero;
    logic           dec_uncd, dec_jtype, dec_itype, dec_movf;
    logic           dec_ld, dec_str, dec_short, dec_halt;
    logic [OPW-1:0] dec_alu;
    logic           in_exec, in_mem, in_wb, last_mem;

    assign op4 = opcode_reg[3:0];

    // Opcodes with any bit set above the low nibble decode as NOP.
    generate
        if (MCW > 4) begin : g_hi
            assign hi_zero = (opcode_reg[MCW-1:4] == '0);
        end else begin : g_nohi
            assign hi_zero = 1'b1;
        end
    endgenerate

    always_comb begin
        dec_uncd  = 1'b0;
        dec_jtype = 1'b0;
        dec_itype = 1'b0;
        dec_movf  = 1'b0;
        dec_ld    = 1'b0;
        dec_str   = 1'b0;
        dec_short = 1'b0;
        dec_halt  = 1'b0;
        dec_alu   = '0;
        if (!hi_zero) begin
            dec_short = 1'b1;
        end else begin
            case (op4)
                4'b0000: begin dec_uncd = 1'b1; dec_jtype = 1'b1; dec_short = 1'b1; end
                4'b0001, 4'b0010, 4'b0011, 4'b0100: begin dec_jtype = 1'b1; dec_short = 1'b1; end
                4'b0101: dec_alu = OPW'(3'b000);
                4'b0110: dec_alu = OPW'(3'b011);
                4'b0111: dec_str = 1'b1;
                4'b1000: dec_ld = 1'b1;
                4'b1001: dec_alu = OPW'(3'b110);
                4'b1010: dec_movf = 1'b1;
                4'b1100: begin dec_alu = OPW'(3'b111); dec_short = 1'b1; end
                4'b1101: begin dec_itype = 1'b1; dec_alu = OPW'(3'b001); end
                4'b1110: dec_itype = 1'b1;
                4'b1111: dec_halt = 1'b1;
                default: dec_short = 1'b1;
            endcase
        end
    end

    // Short instructions (jumps, cmp, NOP) retire in EXEC; ld/str detour through MEM.
    always_comb begin
        state_next  = state_reg;
        opcode_next = opcode_reg;
        cnt_next    = cnt_reg;
        case (state_reg)
            S_IDLE:   if (Start) state_next = S_FETCH;
            S_FETCH:  begin
                opcode_next = Instr;
                state_next  = S_DECODE;
            end
            S_DECODE: state_next = dec_halt ? S_HALT : S_EXEC;
            S_EXEC:   begin
                if (dec_short) begin
                    state_next = S_FETCH;
                end else if (dec_ld || dec_str) begin
                    state_next = S_MEM;
                    cnt_next   = CNT_LOAD;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM:    begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) state_next = dec_ld ? S_WB : S_FETCH;
            end
            S_WB:     state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg  <= S_IDLE;
            opcode_reg <= '0;
            cnt_reg    <= 4'd0;
        end else begin
            state_reg  <= state_next;
            opcode_reg <= opcode_next;
            cnt_reg    <= cnt_next;
        end
    end

    assign in_exec  = (state_reg == S_EXEC);
    assign in_mem   = (state_reg == S_MEM);
    assign in_wb    = (state_reg == S_WB);
    assign last_mem = in_mem && (cnt_reg == 4'd1);

    // ALU/immediate/move selects stay valid through WB so the write-back sees them.
    assign IRLoad   = (state_reg == S_FETCH);
    assign UncdJmp  = in_exec && dec_uncd;
    assign JType    = in_exec && dec_jtype;
    assign IType    = (in_exec || in_wb) && dec_itype;
    assign Movf     = (in_exec || in_wb) && dec_movf;
    assign ALUOp    = (in_exec || in_wb) ? dec_alu : '0;
    assign RdMem    = in_mem && dec_ld;
    assign WrMem    = in_mem && dec_str;
    assign RegWrite = in_wb;
    assign PCEn     = (in_exec && dec_short) || in_wb || (last_mem && dec_str);
    assign Busy     = (state_reg != S_IDLE) && (state_reg != S_HALT);
    assign Halted   = (state_reg == S_HALT);

endmodule
